// File: rtl/lab_pkg.sv
// Shared definitions for the truth-table checker.
//   state_t  : sweep FSM states, 2-bit encoding
//   SETTLE_W : width of the settle down-counter (holds SETTLE-1, SETTLE <= 15)
package lab_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int SETTLE_W = 4;

endpackage

// File: rtl/lab_settle_timer.sv
// Load/expire down-counter used to hold each vector for a fixed number of cycles.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : reload the counter with load_val (has priority)
//   load_val   : number of cycles minus one that the counter runs
//   expired    : counter has reached zero
module lab_settle_timer
    import lab_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [SETTLE_W-1:0] load_val,
    output logic                expired
);

    logic [SETTLE_W-1:0] cnt_q;
    logic [SETTLE_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/lab4_tt_checker.sv
// Truth-table sweeper: drives every input vector 0..2^N_IN-1 into an external
// combinational function, compares its output against a golden truth table
// and reports mismatch count, first failing vector and pass/fail.
//   CL2947MP_clk, CL2947MP_rst_n : clock, synchronous active-low reset
//   CL2947MP_start               : sweep request
//   CL2947MP_stop_first          : end sweep at first mismatch (latched at start)
//   CL2947MP_golden              : golden table, bit i = f(i) (latched at start)
//   CL2947MP_dut_out             : function output for CL2947MP_vec
//   CL2947MP_vec                 : vector driven to the function
//   CL2947MP_busy / _done        : sweep in progress / one-cycle finish pulse
//   CL2947MP_pass                : zero mismatches in the last sweep
//   CL2947MP_err_cnt             : mismatch count (N_IN+1 bits, cannot overflow)
//   CL2947MP_first_err / _vld    : first mismatching vector and its valid flag
//
// Handshake: start is a level request sampled on each rising edge; it is taken
// only when the FSM is in IDLE, and ignored in every other state. A start held
// high re-triggers as soon as the FSM returns to IDLE.
module lab4_tt_checker
    import lab_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic              CL2947MP_clk,
    input  logic              CL2947MP_rst_n,
    input  logic              CL2947MP_start,
    input  logic              CL2947MP_stop_first,
    input  logic [2**N_IN-1:0] CL2947MP_golden,
    input  logic              CL2947MP_dut_out,
    output logic [N_IN-1:0]   CL2947MP_vec,
    output logic              CL2947MP_busy,
    output logic              CL2947MP_done,
    output logic              CL2947MP_pass,
    output logic [N_IN:0]     CL2947MP_err_cnt,
    output logic [N_IN-1:0]   CL2947MP_first_err,
    output logic              CL2947MP_first_vld
);

    localparam int                  NV          = 2**N_IN;
    localparam logic [N_IN-1:0]     VEC_LAST    = '1;
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE - 1);

    state_t            state_q, state_d;
    logic [NV-1:0]     golden_q, golden_d;
    logic              stop_q, stop_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [N_IN:0]     err_cnt_q, err_cnt_d;
    logic [N_IN-1:0]   first_err_q, first_err_d;
    logic              first_vld_q, first_vld_d;

    logic tmr_load;
    logic tmr_expired;
    logic mismatch;

    lab_settle_timer u_settle_timer (
        .clk      (CL2947MP_clk),
        .rst_n    (CL2947MP_rst_n),
        .load     (tmr_load),
        .load_val (SETTLE_LOAD),
        .expired  (tmr_expired)
    );

    // Only meaningful in CHECK; dut_out is ignored in every other state.
    assign mismatch = (CL2947MP_dut_out != golden_q[vec_q]);

    always_comb begin
        state_d     = state_q;
        golden_d    = golden_q;
        stop_d      = stop_q;
        vec_d       = vec_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        first_vld_d = first_vld_q;
        tmr_load    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (CL2947MP_start) begin
                    golden_d    = CL2947MP_golden;
                    stop_d      = CL2947MP_stop_first;
                    vec_d       = '0;
                    err_cnt_d   = '0;
                    first_vld_d = 1'b0;
                    pass_d      = 1'b0;
                    busy_d      = 1'b1;
                    tmr_load    = 1'b1;
                    state_d     = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (tmr_expired) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                    if (!first_vld_q) begin
                        first_err_d = vec_q;
                        first_vld_d = 1'b1;
                    end
                end
                if ((vec_q == VEC_LAST) || (stop_q && mismatch)) begin
                    // vec stays on the last checked vector; pass is set here
                    // so it is already valid while done is high.
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt_d == '0);
                end else begin
                    vec_d    = vec_q + 1'b1;
                    tmr_load = 1'b1;
                    state_d  = ST_SETTLE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                pass_d  = (err_cnt_q == '0);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CL2947MP_clk) begin
        if (!CL2947MP_rst_n) begin
            state_q     <= ST_IDLE;
            golden_q    <= '0;
            stop_q      <= 1'b0;
            vec_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            first_vld_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            golden_q    <= golden_d;
            stop_q      <= stop_d;
            vec_q       <= vec_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            first_vld_q <= first_vld_d;
        end
    end

    assign CL2947MP_vec       = vec_q;
    assign CL2947MP_busy      = busy_q;
    assign CL2947MP_done      = done_q;
    assign CL2947MP_pass      = pass_q;
    assign CL2947MP_err_cnt   = err_cnt_q;
    assign CL2947MP_first_err = first_err_q;
    assign CL2947MP_first_vld = first_vld_q;

endmodule
